// File: rtl/drum_event_spi_tx_if.sv
// Drum event / SPI slave bundle: upstream trigger inputs, MCU SPI pins and status flags.
// The master side drives triggers and the SPI clock/select; the slave side answers on MISO.
interface drum_event_spi_tx_if;
   logic       drum_trigger_valid;
   logic [3:0] drum_code;
   logic       drum_hand;
   logic       spi_sclk;
   logic       spi_cs_n;
   logic       spi_miso;
   logic       event_pending;
   logic       overflow_sticky;

   modport master (
      output drum_trigger_valid, drum_code, drum_hand, spi_sclk, spi_cs_n,
      input  spi_miso, event_pending, overflow_sticky
   );

   modport slave (
      input  drum_trigger_valid, drum_code, drum_hand, spi_sclk, spi_cs_n,
      output spi_miso, event_pending, overflow_sticky
   );
endinterface

// File: rtl/drum_event_spi_tx.sv
// Queues drum trigger events in a small FIFO and serves one event per SPI mode-0 read.
// The byte is snapshotted at CS fall; it is popped only when a full 8-bit read completes.
module drum_event_spi_tx #(
   parameter int DEPTH = 8
) (
   input logic                clk,
   input logic                rst_n,
   drum_event_spi_tx_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;

   logic          valid_d_r;
   logic [4:0]    mem_r [DEPTH];
   logic [AW:0]   wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
   logic [4:0]    head_s;
   logic          full_s, empty_s, push_s, pop_s, push_ok_s, drop_s, commit_s;
   logic [2:0]    sclk_sync_r, cs_sync_r;
   logic          sclk_rise_s, sclk_fall_s, cs_fall_s, cs_rise_s;
   state_t        state_r, state_nxt_s;
   logic [7:0]    shift_r, shift_nxt_s;
   logic [3:0]    bit_cnt_r, bit_cnt_nxt_s;
   logic          valid_snap_r, ovf_snap_r, ovf_r, pending_r, miso_r;

   assign push_s    = bus.drum_trigger_valid && !valid_d_r;
   assign empty_s   = (wr_ptr_r == rd_ptr_r);
   assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign head_s    = mem_r[rd_ptr_r[AW-1:0]];
   assign commit_s  = (state_r == ST_SHIFT) && cs_rise_s && (bit_cnt_r == 4'd8);
   assign pop_s     = commit_s && valid_snap_r;
   // A pop on the same cycle frees a slot, so a push into a full FIFO is still accepted.
   assign push_ok_s = push_s && (!full_s || pop_s);
   assign drop_s    = push_s && full_s && !pop_s;

   assign wr_ptr_nxt_s = push_ok_s ? (wr_ptr_r + {{AW{1'b0}}, 1'b1}) : wr_ptr_r;
   assign rd_ptr_nxt_s = pop_s     ? (rd_ptr_r + {{AW{1'b0}}, 1'b1}) : rd_ptr_r;

   assign sclk_rise_s =  sclk_sync_r[1] && !sclk_sync_r[2];
   assign sclk_fall_s = !sclk_sync_r[1] &&  sclk_sync_r[2];
   assign cs_rise_s   =  cs_sync_r[1]   && !cs_sync_r[2];
   assign cs_fall_s   = !cs_sync_r[1]   &&  cs_sync_r[2];

   // Trigger edge register, SPI pin synchronizers and FIFO pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_d_r   <= 1'b0;
         sclk_sync_r <= 3'b000;
         cs_sync_r   <= 3'b111;
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
      end else begin
         valid_d_r   <= bus.drum_trigger_valid;
         sclk_sync_r <= {sclk_sync_r[1:0], bus.spi_sclk};
         cs_sync_r   <= {cs_sync_r[1:0], bus.spi_cs_n};
         wr_ptr_r    <= wr_ptr_nxt_s;
         rd_ptr_r    <= rd_ptr_nxt_s;
      end
   end

   // FIFO storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 5'd0;
         end
      end else if (push_ok_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= {bus.drum_hand, bus.drum_code};
      end
   end

   // SPI next-state, bit counter and shift register.
   always_comb begin
      state_nxt_s   = state_r;
      shift_nxt_s   = shift_r;
      bit_cnt_nxt_s = bit_cnt_r;
      case (state_r)
         ST_IDLE: begin
            bit_cnt_nxt_s = 4'd0;
            if (cs_fall_s) begin
               state_nxt_s = ST_LOAD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            bit_cnt_nxt_s = 4'd0;
            state_nxt_s   = ST_SHIFT;
            if (empty_s) begin
               shift_nxt_s = {2'b00, ovf_r, 5'b00000};
            end else begin
               shift_nxt_s = {1'b1, head_s[4], ovf_r, 1'b0, head_s[3:0]};
            end
         end
         ST_SHIFT: begin
            if (cs_rise_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_SHIFT;
               if (sclk_rise_s && (bit_cnt_r != 4'd8)) begin
                  bit_cnt_nxt_s = bit_cnt_r + 4'd1;
               end else begin
                  bit_cnt_nxt_s = bit_cnt_r;
               end
               if (sclk_fall_s) begin
                  shift_nxt_s = {shift_r[6:0], 1'b0};
               end else begin
                  shift_nxt_s = shift_r;
               end
            end
         end
         default: begin
            state_nxt_s   = ST_IDLE;
            bit_cnt_nxt_s = 4'd0;
         end
      endcase
   end

   // SPI state, snapshots and registered outputs; MISO follows the next shift value to save a cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         shift_r      <= 8'd0;
         bit_cnt_r    <= 4'd0;
         valid_snap_r <= 1'b0;
         ovf_snap_r   <= 1'b0;
         ovf_r        <= 1'b0;
         pending_r    <= 1'b0;
         miso_r       <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         shift_r   <= shift_nxt_s;
         bit_cnt_r <= bit_cnt_nxt_s;
         if (state_r == ST_LOAD) begin
            valid_snap_r <= !empty_s;
            ovf_snap_r   <= ovf_r;
         end
         if (drop_s) begin
            ovf_r <= 1'b1;
         end else if (commit_s && ovf_snap_r) begin
            ovf_r <= 1'b0;
         end
         pending_r <= (wr_ptr_nxt_s != rd_ptr_nxt_s);
         miso_r    <= (state_nxt_s == ST_SHIFT) ? shift_nxt_s[7] : 1'b0;
      end
   end

   assign bus.spi_miso        = miso_r;
   assign bus.event_pending   = pending_r;
   assign bus.overflow_sticky = ovf_r;
endmodule

// File: tb/tb_drum_event_spi_tx.sv
// Directed bench for drum_event_spi_tx: a queue model of the event FIFO predicts each SPI byte,
// expected bytes are queued when a read starts and compared when the read finishes.
module tb_drum_event_spi_tx;
   localparam int DEPTH = 8;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [4:0] model_q[$];
   logic       model_ovf;
   logic [7:0] exp_q[$];

   drum_event_spi_tx_if bus ();

   drum_event_spi_tx #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] model_byte();
      if (model_q.size() > 0) begin
         return {1'b1, model_q[0][4], model_ovf, 1'b0, model_q[0][3:0]};
      end else begin
         return {2'b00, model_ovf, 5'b00000};
      end
   endfunction

   task automatic model_push(input logic [3:0] code, input logic hand);
      if (model_q.size() < DEPTH) model_q.push_back({hand, code});
      else model_ovf = 1'b1;
   endtask

   task automatic model_commit(input logic [7:0] served);
      if (served[7]) void'(model_q.pop_front());
      if (served[5]) model_ovf = 1'b0;
   endtask

   task automatic trig(input logic [3:0] code, input logic hand);
      @(negedge clk);
      bus.drum_trigger_valid = 1'b1;
      bus.drum_code = code;
      bus.drum_hand = hand;
      model_push(code, hand);
      repeat (6) @(negedge clk);
      bus.drum_trigger_valid = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   // Mode-0 read: MISO sampled just before each SCLK rise; optional trigger timed onto the commit edge.
   task automatic spi_xfer(input int nbits, input bit tr, input logic [3:0] tc, input logic th,
                           output logic [7:0] rx);
      rx = 8'd0;
      @(negedge clk);
      bus.spi_cs_n = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         rx = {rx[6:0], bus.spi_miso};
         bus.spi_sclk = 1'b1;
         repeat (5) @(negedge clk);
         bus.spi_sclk = 1'b0;
         repeat (5) @(negedge clk);
      end
      bus.spi_cs_n = 1'b1;
      if (tr) begin
         repeat (2) @(negedge clk);
         bus.drum_trigger_valid = 1'b1;
         bus.drum_code = tc;
         bus.drum_hand = th;
         repeat (6) @(negedge clk);
         bus.drum_trigger_valid = 1'b0;
      end
      repeat (6) @(negedge clk);
   endtask

   task automatic full_read(input string tag, input bit tr, input logic [3:0] tc, input logic th);
      logic [7:0] rx;
      logic [7:0] e;
      exp_q.push_back(model_byte());
      spi_xfer(8, tr, tc, th, rx);
      e = exp_q.pop_front();
      chk(tag, rx, e);
      model_commit(e);
      if (tr) model_push(tc, th);
   endtask

   initial begin
      logic [7:0] rx;
      model_ovf = 1'b0;
      rst_n = 1'b0;
      bus.drum_trigger_valid = 1'b0;
      bus.drum_code = 4'd0;
      bus.drum_hand = 1'b0;
      bus.spi_sclk = 1'b0;
      bus.spi_cs_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_miso", {7'd0, bus.spi_miso}, 8'd0);
      chk("rst_pending", {7'd0, bus.event_pending}, 8'd0);
      chk("rst_ovf", {7'd0, bus.overflow_sticky}, 8'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single event, with push-latency check one edge after valid rises.
      @(negedge clk);
      bus.drum_trigger_valid = 1'b1;
      bus.drum_code = 4'd5;
      bus.drum_hand = 1'b1;
      model_push(4'd5, 1'b1);
      @(negedge clk);
      chk("push_latency_pending", {7'd0, bus.event_pending}, 8'd1);
      repeat (5) @(negedge clk);
      bus.drum_trigger_valid = 1'b0;
      repeat (3) @(negedge clk);
      full_read("single_c5", 1'b0, 4'd0, 1'b0);
      chk("single_pending_after", {7'd0, bus.event_pending}, 8'd0);

      // Empty poll.
      full_read("empty_poll", 1'b0, 4'd0, 1'b0);
      chk("empty_pending", {7'd0, bus.event_pending}, 8'd0);

      // Overflow: nine events into eight slots.
      for (int i = 0; i < 9; i++) trig(4'(i), 1'b0);
      chk("ovf_set", {7'd0, bus.overflow_sticky}, 8'd1);
      full_read("ovf_read1", 1'b0, 4'd0, 1'b0);
      chk("ovf_cleared", {7'd0, bus.overflow_sticky}, 8'd0);
      for (int i = 1; i < 9; i++) full_read($sformatf("ovf_read%0d", i + 1), 1'b0, 4'd0, 1'b0);
      chk("ovf_pending_end", {7'd0, bus.event_pending}, 8'd0);

      // Aborted read after five clocks re-serves the same byte.
      trig(4'd3, 1'b0);
      spi_xfer(5, 1'b0, 4'd0, 1'b0, rx);
      chk("abort_partial_bits", {3'd0, rx[4:0]}, {3'd0, model_byte() >> 3});
      chk("abort_pending", {7'd0, bus.event_pending}, 8'd1);
      full_read("abort_reread_83", 1'b0, 4'd0, 1'b0);
      chk("abort_pending_after", {7'd0, bus.event_pending}, 8'd0);

      // Full FIFO, push landing on the commit edge.
      for (int i = 0; i < DEPTH; i++) trig(4'(8 + i), 1'(i % 2));
      full_read("simul_first", 1'b1, 4'd2, 1'b0);
      chk("simul_no_ovf", {7'd0, bus.overflow_sticky}, 8'd0);
      chk("simul_pending", {7'd0, bus.event_pending}, 8'd1);
      for (int i = 0; i < DEPTH; i++) full_read($sformatf("simul_drain%0d", i), 1'b0, 4'd0, 1'b0);
      full_read("simul_empty", 1'b0, 4'd0, 1'b0);

      // Reset in the middle of a shift.
      for (int i = 0; i < 3; i++) trig(4'(i + 1), 1'b1);
      @(negedge clk);
      bus.spi_cs_n = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         bus.spi_sclk = 1'b1;
         repeat (5) @(negedge clk);
         bus.spi_sclk = 1'b0;
         repeat (5) @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      chk("midrst_miso", {7'd0, bus.spi_miso}, 8'd0);
      chk("midrst_pending", {7'd0, bus.event_pending}, 8'd0);
      model_q.delete();
      model_ovf = 1'b0;
      @(negedge clk);
      bus.spi_cs_n = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      full_read("post_rst_read", 1'b0, 4'd0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/drum_event_spi_tx.md
# drum_event_spi_tx

Downstream of the drum trigger processor. Captures each new drum trigger event (`drum_trigger_valid`, `drum_code`, `drum_hand`) into a small FIFO and serves one event per SPI transaction to the MCU, acting as an SPI mode-0 slave. `event_pending` tells the MCU when to poll. Trigger pulses are several cycles long and the MCU polls asynchronously, so events are queued here rather than lost.

## Interface
- `DEPTH`, 8: FIFO entries. Must be a power of 2 and at least 2.
- `clk`  in  1  system clock. Must be at least 8× the SPI SCLK frequency.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `drum_trigger_valid`  in  1  trigger from upstream. Held high for 6+ cycles per event.
- `drum_code`  in  4  drum code. Stable while valid is high.
- `drum_hand`  in  1  0 = right, 1 = left.
- `spi_sclk`  in  1  SPI clock from the MCU. Asynchronous.
- `spi_cs_n`  in  1  SPI chip select, active-low. Asynchronous.
- `spi_miso`  out  1  serial data to the MCU, MSB first.
- `event_pending`  out  1  high while the FIFO is non-empty.
- `overflow_sticky`  out  1  high from a dropped event until it is reported.

## Operation
- **Event capture.**
  - Register `valid_d` = previous `drum_trigger_valid`.
  - A push request occurs when `drum_trigger_valid && !valid_d`. Capture `{drum_hand, drum_code}` on that cycle.
  - A retrigger while valid stays high is not a new event.
- **FIFO.**
  - `DEPTH` × 5 bits, with read/write pointers of log2(DEPTH)+1 bits.
  - Full when the pointer MSBs differ and the lower bits are equal. Empty when the pointers are equal.
  - Push while full: the event is dropped and `overflow_sticky` is set. Pointers are unchanged.
  - Push and commit-pop on the same cycle: both take effect and the count is unchanged. This also applies when full: the push is accepted and no overflow is flagged.
- **SPI synchronisation.**
  - `spi_sclk` and `spi_cs_n` each pass through a 2-FF synchronizer, then a third register for edge detection.
  - Derived events: `cs_fall`, `cs_rise`, `sclk_rise`, `sclk_fall`.
- **SPI state machine:** IDLE → LOAD → SHIFT → IDLE.
  - IDLE: `spi_miso` = 0, bit counter = 0. On `cs_fall`, go to LOAD.
  - LOAD (one cycle): snapshot the response byte into an 8-bit shift register, and snapshot `ovf_snap` = `overflow_sticky`.
    - Response byte = `{!empty, head_hand, ovf_snap, 1'b0, head_code}`.
    - When empty, the byte is `{0, 0, ovf_snap, 0, 4'h0}`.
    - Go to SHIFT.
  - SHIFT:
    - `spi_miso` = shift register bit 7.
    - `sclk_rise`: increment the bit counter, saturating at 8.
    - `sclk_fall`: shift left, filling with 0.
    - Bits beyond 8 read as 0.
    - On `cs_rise`, go to IDLE. Commit only if the bit counter reached 8.
- **Commit** (on the `cs_rise` cycle, counter = 8):
  - If the snapshot had valid = 1, pop the head.
  - If `ovf_snap` = 1, clear `overflow_sticky`. A new overflow on the same cycle wins and keeps it set.
- **Aborted transaction** (`cs_rise` with counter < 8): no pop, no clear. The same byte is re-served next time.
- FIFO contents are untouched between LOAD and commit. Pushes during a transaction are accepted and never alter the in-flight byte.
- A `cs_fall` arriving while in SHIFT is not possible, because `cs_rise` precedes it. A glitch shorter than 2 clk may be missed; this is allowed.

## Timing
- **Reset values:**
  - Outputs: `spi_miso` = 0, `event_pending` = 0, `overflow_sticky` = 0.
  - Internal: FIFO empty, state IDLE, synchronizers reset to `sclk` = 0 and `cs_n` = 1, `valid_d` = 0.
  - Reset mid-transaction discards the transaction and the FIFO. The MCU sees `spi_miso` = 0.
- **Push latency:** valid rises at edge N. The entry is written at edge N+1. `event_pending` is high after edge N+1.
- **`event_pending`:** registered, equal to `!empty` of the current pointers. Falls the cycle after the commit that empties the FIFO.
- **CS to first SCLK:** `spi_miso` shows bit 7 within 4 clk of the `spi_cs_n` pin falling. The MCU waits ≥ 4 clk before the first SCLK rising edge.
- **Per-bit latency:** `spi_miso` updates 3 clk after each SCLK pin falling edge. This requires an SCLK half-period ≥ 4 clk.
- **Commit latency:** the pop happens 3 clk after the `spi_cs_n` pin rises. The next `cs_fall` must come ≥ 2 clk later.

## Test plan
- **Single event:** valid high 6 cycles with code 5, hand 1, then one 8-bit SPI read → MISO byte 0xC5. `event_pending` goes 1 → 0 after CS rises.
- **Empty poll:** SPI read with the FIFO empty → 0x00. No pointer change.
- **Overflow:** DEPTH+1 = 9 events (codes 0–8, hand 0), then 9 reads:
  - Reads 1–8 return 0x80–0x87, with bit 5 set in read 1 only.
  - `overflow_sticky` clears after read 1.
  - Read 9 returns 0x00.
- **Aborted read:** one event (code 3, hand 0), CS raised after 5 SCLKs → no pop. A full read then returns 0x83 and the FIFO empties.
- **Simultaneous push/commit:** with the FIFO full, time a new valid rising edge so its push lands on the commit cycle → count stays DEPTH and no overflow is flagged. Subsequent reads return the order oldest → newest.
- **Reset mid-shift:** assert `rst_n` low after 4 SCLKs with 3 events queued → `spi_miso` = 0, `event_pending` = 0. A read after reset returns 0x00.
